// File: rtl/pcal_pkg.sv
// Shared types and constants for the stack-calculator program loader.
// Holds the loader state enum, default widths and the program-word encoding.
package pcal_pkg;

    localparam int PCAL_AW = 10;
    localparam int PCAL_DW = 16;

    typedef enum logic [2:0] {
        LOAD,
        FLUSH,
        START,
        WAIT_LOW,
        WAIT_HIGH,
        RESULT
    } pcal_ldr_state_t;

    // Program-word encoding: bit15=0 pushes bits 14:0, 10 = operator, 11 = halt.
    localparam logic [15:0] PW_PUSH = 16'h0000;
    localparam logic [15:0] PW_OP   = 16'h8000;
    localparam logic [15:0] PW_HALT = 16'hC000;

    localparam logic [2:0] OP_NEG = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;

    function automatic logic [15:0] pcal_op_word(input logic [2:0] code);
        return PW_OP | {13'b0, code};
    endfunction

endpackage

// File: rtl/pcal_ldr_watchdog.sv
// Run-time watchdog for the loader: a 16-bit cycle counter with clear and enable.
// o_expired stays high once the count reaches LIMIT until the next clear.
module pcal_ldr_watchdog #(
    parameter logic [15:0] LIMIT = 16'hFFFF
) (
    input  logic clk,
    input  logic nrst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [15:0] r_cnt;

    assign o_expired = (r_cnt == LIMIT);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/pcal_loader.sv
// Host-side loader: streams program words into the calculator, starts it and returns the result.
// Build option PCAL_LDR_TIMEOUT_EN adds a watchdog that reports a hung run via res_err.
module pcal_loader
    import pcal_pkg::*;
#(
    parameter int AW      = PCAL_AW,
    parameter int DW      = PCAL_DW,
    parameter int TIMEOUT = 65535
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic [DW-1:0] s_data,
    input  logic          s_last,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [DW-1:0] res_data,
    output logic          res_valid,
    input  logic          res_ack,
    output logic          res_err,
    output logic          busy,
    output logic [AW-1:0] c_addr,
    output logic          c_wr,
    output logic [DW-1:0] c_datain,
    output logic          c_start,
    input  logic          c_ready,
    input  logic [DW-1:0] c_out
);

    pcal_ldr_state_t r_state, w_state_nxt;

    logic [AW-1:0] r_ptr, w_ptr_nxt;
    logic [AW-1:0] r_addr, w_addr_nxt;
    logic [DW-1:0] r_datain, w_datain_nxt;
    logic [DW-1:0] r_res_data, w_res_data_nxt;
    logic          r_wr, w_wr_nxt;
    logic          r_start, w_start_nxt;
    logic          r_res_valid, w_res_valid_nxt;
    logic          r_res_err, w_res_err_nxt;

    logic w_accept;
    logic w_last;
    logic w_expired;

    assign w_accept = s_valid && (r_state == LOAD);
    // The top address is always the final word so the pointer can never wrap onto word 0.
    assign w_last   = s_last || (r_ptr == {AW{1'b1}});

`ifdef PCAL_LDR_TIMEOUT_EN
    pcal_ldr_watchdog #(
        .LIMIT (TIMEOUT[15:0])
    ) u_watchdog (
        .clk       (clk),
        .nrst      (nrst),
        .i_clr     (r_state == START),
        .i_en      ((r_state == WAIT_LOW) || (r_state == WAIT_HIGH)),
        .o_expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    // NOTE: every output is a flop with async reset, so a mid-run nrst clears all of them at once.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= LOAD;
            r_ptr       <= '0;
            r_addr      <= '0;
            r_datain    <= '0;
            r_wr        <= 1'b0;
            r_start     <= 1'b0;
            r_res_data  <= '0;
            r_res_valid <= 1'b0;
            r_res_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_addr      <= w_addr_nxt;
            r_datain    <= w_datain_nxt;
            r_wr        <= w_wr_nxt;
            r_start     <= w_start_nxt;
            r_res_data  <= w_res_data_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_res_err   <= w_res_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LOAD:      if (w_accept && w_last) w_state_nxt = FLUSH;
            FLUSH:     w_state_nxt = START;
            START:     w_state_nxt = WAIT_LOW;
            WAIT_LOW: begin
                if (w_expired)     w_state_nxt = RESULT;
                else if (!c_ready) w_state_nxt = WAIT_HIGH;
            end
            WAIT_HIGH: if (c_ready || w_expired) w_state_nxt = RESULT;
            RESULT:    if (res_ack) w_state_nxt = LOAD;
            default:   w_state_nxt = LOAD;
        endcase
    end

    // Next values for the registered outputs; write and start strobes default low.
    always_comb begin
        w_ptr_nxt       = r_ptr;
        w_addr_nxt      = r_addr;
        w_datain_nxt    = r_datain;
        w_wr_nxt        = 1'b0;
        w_start_nxt     = 1'b0;
        w_res_data_nxt  = r_res_data;
        w_res_valid_nxt = r_res_valid;
        w_res_err_nxt   = r_res_err;
        case (r_state)
            LOAD: begin
                if (w_accept) begin
                    w_wr_nxt     = 1'b1;
                    w_addr_nxt   = r_ptr;
                    w_datain_nxt = s_data;
                    w_ptr_nxt    = r_ptr + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            FLUSH: w_start_nxt = 1'b1;
            WAIT_LOW: begin
                if (w_expired) begin
                    w_res_data_nxt  = '0;
                    w_res_valid_nxt = 1'b1;
                    w_res_err_nxt   = 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (c_ready) begin
                    w_res_data_nxt  = c_out;
                    w_res_valid_nxt = 1'b1;
                    w_res_err_nxt   = 1'b0;
                end else if (w_expired) begin
                    w_res_data_nxt  = '0;
                    w_res_valid_nxt = 1'b1;
                    w_res_err_nxt   = 1'b1;
                end
            end
            RESULT: begin
                if (res_ack) begin
                    w_res_valid_nxt = 1'b0;
                    w_ptr_nxt       = '0;
                end
            end
            default: ;
        endcase
    end

    assign s_ready   = (r_state == LOAD);
    assign busy      = (r_state != LOAD);
    assign c_addr    = r_addr;
    assign c_wr      = r_wr;
    assign c_datain  = r_datain;
    assign c_start   = r_start;
    assign res_data  = r_res_data;
    assign res_valid = r_res_valid;
    assign res_err   = r_res_err;

endmodule

// File: tb/tb_pcal_loader.sv
// Self-checking bench for pcal_loader with a behavioural stack-calculator model.
// Exercises fixed vectors, random programs, depth overflow, mid-run reset and the optional watchdog.
module tb_pcal_loader;
    import pcal_pkg::*;

    localparam int AW    = 10;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] res_data;
    logic          res_valid;
    logic          res_ack = 1'b0;
    logic          res_err;
    logic          busy;
    logic [AW-1:0] c_addr;
    logic          c_wr;
    logic [DW-1:0] c_datain;
    logic          c_start;
    logic          c_ready;
    logic [DW-1:0] c_out;

    always #5 clk = ~clk;

    pcal_loader #(.AW(AW), .DW(DW), .TIMEOUT(100)) dut (
        .clk(clk), .nrst(nrst),
        .s_data(s_data), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
        .res_data(res_data), .res_valid(res_valid), .res_ack(res_ack), .res_err(res_err),
        .busy(busy),
        .c_addr(c_addr), .c_wr(c_wr), .c_datain(c_datain), .c_start(c_start),
        .c_ready(c_ready), .c_out(c_out)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference semantics of a program: plain stack arithmetic on a queue.
    function automatic logic [15:0] eval_prog(input logic [15:0] prog[$]);
        logic [15:0] st[$];
        logic [15:0] a, b, w;
        foreach (prog[i]) begin
            w = prog[i];
            if (w[15:14] == 2'b11) break;
            if (!w[15]) begin
                st.push_back({1'b0, w[14:0]});
            end else begin
                b = (st.size() > 0) ? st.pop_back() : 16'h0;
                case (w[2:0])
                    OP_NEG: st.push_back(16'h0 - b);
                    OP_ADD: begin a = (st.size() > 0) ? st.pop_back() : 16'h0; st.push_back(a + b); end
                    OP_MUL: begin a = (st.size() > 0) ? st.pop_back() : 16'h0; st.push_back(a * b); end
                    default: st.push_back(b);
                endcase
            end
        end
        return (st.size() > 0) ? st[st.size()-1] : 16'h0;
    endfunction

    // Calculator model: memory written by c_wr, runs on c_start after calc_lat cycles.
    logic [15:0] calc_mem [DEPTH];
    int          calc_cnt;
    int          calc_lat  = 3;
    bit          calc_hang = 1'b0;

    function automatic logic [15:0] run_mem();
        logic [15:0] q[$];
        for (int i = 0; i < DEPTH; i++) begin
            q.push_back(calc_mem[i]);
            if (calc_mem[i][15:14] == 2'b11) break;
        end
        return eval_prog(q);
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            c_ready  <= 1'b1;
            c_out    <= 16'h0;
            calc_cnt <= 0;
        end else begin
            if (c_wr) calc_mem[c_addr] <= c_datain;
            if (c_start) begin
                c_ready  <= 1'b0;
                calc_cnt <= calc_lat;
            end else if (!c_ready && !calc_hang) begin
                if (calc_cnt == 0) begin
                    c_ready <= 1'b1;
                    c_out   <= run_mem();
                end else begin
                    calc_cnt <= calc_cnt - 1;
                end
            end
        end
    end

    typedef struct {
        int          cyc;
        int          addr;
        logic [15:0] data;
    } wr_t;

    wr_t wr_log[$];
    int  start_cycs[$];
    int  overlap = 0;

    always @(negedge clk) begin
        if (nrst) begin
            if (c_wr) wr_log.push_back('{cyc, int'(c_addr), c_datain});
            if (c_start) begin
                start_cycs.push_back(cyc);
                if (c_wr) overlap++;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the final accept.
    task automatic send_prog(input logic [15:0] prog[$], input bit use_last, input int max_gap,
                             output int t_last);
        int gap;
        int w;
        t_last = -1;
        for (int i = 0; i < prog.size(); i++) begin
            gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
            repeat (gap) begin s_valid = 1'b0; @(negedge clk); end
            s_valid = 1'b1;
            s_data  = prog[i];
            s_last  = use_last && (i == prog.size() - 1);
            #1;
            w = 0;
            while (!s_ready && w < 50) begin @(negedge clk); #1; w++; end
            if (!s_ready) check("accept timeout", 0, 1);
            t_last = cyc;
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_prog(input string nm, input logic [15:0] prog[$], input bit use_last,
                            input int max_gap, input int ack_delay, input logic [15:0] exp);
        int          t_last;
        int          w;
        bit          busy_ok;
        bit          hold_ok;
        bit          wr_ok;
        logic [15:0] held;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        wr_ok   = 1'b1;
        wr_log.delete();
        start_cycs.delete();
        send_prog(prog, use_last, max_gap, t_last);
        w = 0;
        while (!res_valid && w < 3000) begin
            if (s_ready !== 1'b0 || busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            w++;
        end
        check({nm, " res_valid"}, res_valid, 1);
        check({nm, " start count"}, start_cycs.size(), 1);
        check({nm, " start delay"}, (start_cycs.size() > 0) ? start_cycs[0] - t_last : -1, 2);
        check({nm, " write count"}, wr_log.size(), prog.size());
        foreach (wr_log[i])
            if (i >= prog.size() || wr_log[i].addr != i || wr_log[i].data !== prog[i]) wr_ok = 1'b0;
        check({nm, " write order"}, wr_ok, 1);
        check({nm, " res_data"}, res_data, exp);
        check({nm, " res_err"}, res_err, 0);
        check({nm, " s_ready low while busy"}, busy_ok, 1);
        held = res_data;
        repeat (ack_delay) begin
            @(negedge clk);
            if (res_data !== held || res_valid !== 1'b1 || s_ready !== 1'b0) hold_ok = 1'b0;
        end
        check({nm, " result held"}, hold_ok, 1);
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
        check({nm, " released"}, {res_valid, s_ready, busy}, 3'b010);
    endtask

    task automatic gen_prog(output logic [15:0] p[$]);
        int depth;
        int len;
        p.delete();
        depth = 0;
        len   = $urandom_range(10, 2);
        for (int i = 0; i < len; i++) begin
            if (depth < 2 || $urandom_range(1, 0) == 0) begin
                p.push_back({1'b0, 15'($urandom)});
                depth++;
            end else begin
                case ($urandom_range(2, 0))
                    0: p.push_back(pcal_op_word(OP_NEG));
                    1: begin p.push_back(pcal_op_word(OP_ADD)); depth--; end
                    default: begin p.push_back(pcal_op_word(OP_MUL)); depth--; end
                endcase
            end
        end
        p.push_back(PW_HALT);
    endtask

    typedef struct {
        logic [15:0] w[4];
        int          n;
        int          gap;
        int          ack;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [15:0] prog[$];
        logic [15:0] v;
        int          w;
        int          ts;

        vecs[0] = '{'{16'h0005, 16'h0003, 16'h8002, 16'hC000}, 4, 0, 1,  16'h0008};
        vecs[1] = '{'{16'h0006, 16'h0007, 16'h8003, 16'hC000}, 4, 3, 2,  16'h002A};
        vecs[2] = '{'{16'h0006, 16'h0007, 16'h8003, 16'hC000}, 4, 0, 20, 16'h002A};
        vecs[3] = '{'{16'h0009, 16'h8001, 16'hC000, 16'h0000}, 3, 1, 0,  16'hFFF7};
        vecs[4] = '{'{16'h7FFF, 16'h7FFF, 16'h8002, 16'hC000}, 4, 2, 3,  16'hFFFE};

        repeat (3) @(negedge clk);
        check("reset outputs", {c_wr, c_start, res_valid, res_err, s_ready, busy}, 6'b000010);
        check("reset c_addr", c_addr, 0);
        check("reset res_data", res_data, 0);
        nrst = 1'b1;
        @(negedge clk);

        // A stray ack while loading must be ignored.
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
        check("stray ack", {res_valid, s_ready}, 2'b01);

        foreach (vecs[k]) begin
            prog.delete();
            for (int i = 0; i < vecs[k].n; i++) prog.push_back(vecs[k].w[i]);
            run_prog($sformatf("vec%0d", k), prog, 1'b1, vecs[k].gap, vecs[k].ack, vecs[k].exp);
        end

        for (int r = 0; r < 20; r++) begin
            gen_prog(prog);
            calc_lat = $urandom_range(6, 0);
            run_prog($sformatf("rand%0d", r), prog, 1'b1, $urandom_range(3, 0),
                     $urandom_range(5, 0), eval_prog(prog));
        end

        // Full depth without s_last: word 1023 must close the program.
        prog.delete();
        v = 16'h0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            v = {1'b0, 15'($urandom)};
            prog.push_back(v);
        end
        prog.push_back(PW_HALT);
        calc_lat = 3;
        run_prog("full depth", prog, 1'b0, 0, 1, v);

        // Reset while waiting for the calculator to come back.
        calc_lat = 10;
        prog.delete();
        prog.push_back(16'h0011);
        prog.push_back(PW_HALT);
        send_prog(prog, 1'b1, 0, ts);
        w = 0;
        while (c_ready && w < 50) begin @(negedge clk); w++; end
        check("mid-run ready low", c_ready, 0);
        @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        check("async reset outputs", {c_wr, c_start, res_valid, res_err, s_ready, busy}, 6'b000010);
        check("async reset c_addr", c_addr, 0);
        check("async reset c_datain", c_datain, 0);
        check("async reset res_data", res_data, 0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        calc_lat = 2;
        prog.delete();
        prog.push_back(16'h0004);
        prog.push_back(pcal_op_word(OP_NEG));
        prog.push_back(PW_HALT);
        run_prog("after reset", prog, 1'b1, 1, 2, 16'hFFFC);

`ifdef PCAL_LDR_TIMEOUT_EN
        calc_hang = 1'b1;
        start_cycs.delete();
        send_prog(prog, 1'b1, 0, ts);
        w = 0;
        while (!res_valid && w < 500) begin @(negedge clk); w++; end
        check("timeout res_valid", res_valid, 1);
        check("timeout res_err", res_err, 1);
        check("timeout res_data", res_data, 0);
        check("timeout latency", (start_cycs.size() > 0) ? cyc - start_cycs[0] : -1, 102);
        nrst = 1'b0;
        @(negedge clk);
        calc_hang = 1'b0;
        nrst = 1'b1;
        @(negedge clk);
        run_prog("after timeout", prog, 1'b1, 0, 1, 16'hFFFC);
`endif

        check("start/write overlap", overlap, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pcal_loader.md
Name: pcal_loader

Overview:
- Host-side initiator for the programmable stack calculator's load/start/ready interface.
- Accepts a stream of 16-bit program words over valid/ready and writes them to consecutive calculator program addresses from 0.
- On the last word, pulses start, waits for the run to complete, captures the result and presents it through a result valid/ack handshake.
- Sits between a host or bus adapter and the calculator top level.

Parameters:
- AW, 10, calculator program address width (program depth = 2**AW).
- DW, 16, program word and result width.
- TIMEOUT, 65535, watchdog limit in clk cycles; used only with PCAL_LDR_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- s_data  in  DW  program word
- s_last  in  1  marks the final program word
- s_valid  in  1  word offered
- s_ready  out  1  word accepted when s_valid && s_ready
- res_data  out  DW  captured calculator result
- res_valid  out  1  result available
- res_ack  in  1  consumer takes the result
- res_err  out  1  result is a timeout (valid only with res_valid)
- busy  out  1  high in every state except LOAD
- c_addr  out  AW  calculator write address
- c_wr  out  1  calculator write strobe
- c_datain  out  DW  calculator write data
- c_start  out  1  calculator start pulse
- c_ready  in  1  calculator ready/idle
- c_out  in  DW  calculator top-of-stack

Behaviour:
- Reset values: state=LOAD, ptr=0, c_wr=0, c_start=0, c_addr=0, c_datain=0, res_valid=0, res_err=0, res_data=0. Reset mid-run aborts immediately to these values.
- All c_* outputs and all res_* outputs are registered.
- States: LOAD, FLUSH, START, WAIT_LOW, WAIT_HIGH, RESULT.
- LOAD:
  - s_ready=1; all other states s_ready=0.
  - On accept in cycle t: in cycle t+1, c_wr=1, c_addr=ptr, c_datain=s_data. ptr increments (AW bits).
  - If s_last is set, or ptr==2**AW-1, that word is forced as the last word and the state goes to FLUSH.
- FLUSH: one cycle. The final write is on c_wr in this cycle. Go to START.
- START:
  - c_start=1 for exactly this cycle (t+2 after the last accept) and c_wr=0.
  - Start and write never overlap.
  - Go to WAIT_LOW.
- WAIT_LOW: wait for c_ready==0, then go to WAIT_HIGH.
- WAIT_HIGH:
  - In the first cycle with c_ready==1: res_data<=c_out, res_valid<=1, res_err<=0, go to RESULT.
  - The result is visible one cycle after ready rises.
- RESULT:
  - Hold res_data and res_valid until res_ack.
  - On ack: res_valid<=0, ptr<=0, go to LOAD.
  - res_ack outside RESULT is ignored.
- Each run reloads from address 0. A shorter program leaves older words above its end, which is harmless because the halt word terminates execution.
- s_valid held while busy is not accepted. Words are never dropped or duplicated.

Optional Feature:
- Macro: PCAL_LDR_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to WAIT_LOW and counts in WAIT_LOW/WAIT_HIGH.
  - When it reaches TIMEOUT: res_valid=1, res_err=1, res_data=0, go to RESULT.
  - The calculator is not aborted. The host must apply nrst to recover it.
- Not defined: no counter; waiting is unbounded; res_err is tied 0.

Decomposition:
- Package pcal_pkg:
  - state enum pcal_ldr_state_t.
  - AW/DW defaults.
  - Program-word field constants: PUSH bit15=0; OP bit15=1; HALT bits15:14=11; op codes ADD=3'b010, MUL=3'b011, NEG=3'b001.
- Sub-module pcal_ldr_watchdog (counter with clear, enable and expired outputs), instantiated only under PCAL_LDR_TIMEOUT_EN.

Test Plan:
- Stream 0x0005, 0x0003, 0x8002, then 0xC000 with last, into the real calculator. Required: addresses 0–3 written in order, one c_start two cycles after the last accept, res_valid with res_data=0x0008, res_err=0.
- Program 0x0006, 0x0007, 0x8003, 0xC000, with s_valid gaps between words. Required: res_data=0x002A, no duplicate writes, s_ready=0 from the last accept until ack.
- res_ack held low for 20 cycles after the result. Required: res_data stable and s_ready=0 throughout; after ack, s_ready=1 and the next program writes start at c_addr=0.
- 1024 words streamed without s_last. Required: word 1023 is treated as last and start is pulsed.
- With the macro, TIMEOUT=100, and a calculator model that never re-raises ready: res_valid=1, res_err=1, res_data=0 after 100 cycles in the wait states.
- nrst asserted during WAIT_HIGH. Required: all outputs return to reset values asynchronously; a new program then loads from address 0.
